// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running pixel timing generator.
// Horizontal and vertical counters. Every output is decoded from the counter
// registers, so every output matches the current hc/vc.
// Visible coordinates are 1-based, and 0 means blanking.

// Elaboration-time range check: both totals must fit the 11-bit counters.
module vga_timing_gen_param_check #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525
);
   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_range_error
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
   end
   if (H_TOTAL < 1 || V_TOTAL < 1) begin : g_empty_error
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be at least 1");
   end
endmodule

module vga_timing_gen #(
   parameter int   H_VISIBLE = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hc,
   output logic [10:0] vc,
   output logic [10:0] hc_visible,
   output logic [10:0] vc_visible,
   output logic        display_en,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // Region boundaries in counter width. The sync region is inclusive on both ends.
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_LO  = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0] H_SYNC_HI  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_SYNC_LO  = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0] V_SYNC_HI  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

   vga_timing_gen_param_check #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_param_check ();

   logic [10:0] hc_r;
   logic [10:0] vc_r;
   logic        h_vis_s;
   logic        v_vis_s;
   logic        h_sync_s;
   logic        v_sync_s;

   // Pixel/line counters. The line counter advances on the last pixel of each line.
   // A reset abandons the current frame immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         hc_r <= 11'd0;
         vc_r <= 11'd0;
      end else if (hc_r == H_LAST) begin
         hc_r <= 11'd0;
         if (vc_r == V_LAST) begin
            vc_r <= 11'd0;
         end else begin
            vc_r <= vc_r + 11'd1;
         end
      end else begin
         hc_r <= hc_r + 11'd1;
         vc_r <= vc_r;
      end
   end

   // Region decode from the counter registers only. No input reaches the outputs here.
   always_comb begin
      h_vis_s  = (hc_r < H_VIS_END);
      v_vis_s  = (vc_r < V_VIS_END);
      h_sync_s = (hc_r >= H_SYNC_LO) && (hc_r <= H_SYNC_HI);
      v_sync_s = (vc_r >= V_SYNC_LO) && (vc_r <= V_SYNC_HI);
   end

   // Output decode. Visible coordinates are 1-based, and sync levels follow SYNC_POL.
   always_comb begin
      hc          = hc_r;
      vc          = vc_r;
      hc_visible  = 11'd0;
      vc_visible  = 11'd0;
      hsync       = ~SYNC_POL;
      vsync       = ~SYNC_POL;
      if (h_vis_s) begin
         hc_visible = hc_r + 11'd1;
      end else begin
         hc_visible = 11'd0;
      end
      if (v_vis_s) begin
         vc_visible = vc_r + 11'd1;
      end else begin
         vc_visible = 11'd0;
      end
      if (h_sync_s) begin
         hsync = SYNC_POL;
      end else begin
         hsync = ~SYNC_POL;
      end
      if (v_sync_s) begin
         vsync = SYNC_POL;
      end else begin
         vsync = ~SYNC_POL;
      end
      display_en  = h_vis_s && v_vis_s;
      line_start  = (hc_r == 11'd0);
      frame_start = (hc_r == 11'd0) && (vc_r == 11'd0);
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances (default, tiny override, mid-size active-high sync).
// Each output is checked every cycle against a model that takes the elapsed time since
// the last reset and derives the position from it by division and modulo.
// Directed checks cover the line boundaries and the mid-frame reset case.
// Frame statistics and random reset pulses are also checked.
module tb_vga_timing_gen;

   // Tiny override instance.
   localparam int S_HV = 8,  S_HFP = 1, S_HS = 2, S_HBP = 1;
   localparam int S_VV = 4,  S_VFP = 1, S_VS = 1, S_VBP = 1;
   localparam int S_P  = 84;
   // Mid-size instance with active-high sync.
   localparam int M_HV = 64, M_HFP = 4, M_HS = 8, M_HBP = 4;
   localparam int M_VV = 48, M_VFP = 3, M_VS = 2, M_VBP = 5;
   localparam int M_P  = 4640;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [10:0] d_hc, d_vc, d_hcv, d_vcv;
   logic        d_de, d_hs, d_vs, d_ls, d_fs;
   logic [10:0] s_hc, s_vc, s_hcv, s_vcv;
   logic        s_de, s_hs, s_vs, s_ls, s_fs;
   logic [10:0] m_hc, m_vc, m_hcv, m_vcv;
   logic        m_de, m_hs, m_vs, m_ls, m_fs;

   int checks   = 0;
   int failures = 0;
   int t        = 0;
   int stats_on = 0;
   int s_de_n = 0, s_hs_n = 0, s_vs_n = 0, s_ls_n = 0, s_last_fs = -1;
   int m_de_n = 0, m_hs_n = 0, m_vs_n = 0, m_ls_n = 0, m_last_fs = -1;

   always #5 clk = ~clk;

   vga_timing_gen u_dut_def (
      .clk(clk), .rst(rst), .hc(d_hc), .vc(d_vc), .hc_visible(d_hcv), .vc_visible(d_vcv),
      .display_en(d_de), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b0)
   ) u_dut_small (
      .clk(clk), .rst(rst), .hc(s_hc), .vc(s_vc), .hc_visible(s_hcv), .vc_visible(s_vcv),
      .display_en(s_de), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
   );

   vga_timing_gen #(
      .H_VISIBLE(M_HV), .H_FP(M_HFP), .H_SYNC(M_HS), .H_BP(M_HBP),
      .V_VISIBLE(M_VV), .V_FP(M_VFP), .V_SYNC(M_VS), .V_BP(M_VBP), .SYNC_POL(1'b1)
   ) u_dut_mid (
      .clk(clk), .rst(rst), .hc(m_hc), .vc(m_vc), .hc_visible(m_hcv), .vc_visible(m_vcv),
      .display_en(m_de), .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs)
   );

   // Compare one observed value with its expected value and record the result.
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Expected outputs after t cycles of free running from (0,0).
   // Packing order: {hc, vc, hc_visible, vc_visible, display_en, hsync, vsync, line_start, frame_start}.
   function automatic logic [48:0] model_outs(input int tt,
                                              input int hv, input int hfp, input int hsw, input int hbp,
                                              input int vv, input int vfp, input int vsw, input int vbp,
                                              input logic pol);
      int ht, vt, h, v;
      logic [10:0] hcv, vcv;
      logic de, hs, vs, ls, fs;
      ht  = hv + hfp + hsw + hbp;
      vt  = vv + vfp + vsw + vbp;
      h   = tt % ht;
      v   = (tt / ht) % vt;
      hcv = (h < hv) ? 11'(h + 1) : 11'd0;
      vcv = (v < vv) ? 11'(v + 1) : 11'd0;
      de  = (h < hv) && (v < vv);
      hs  = (h >= hv + hfp && h < hv + hfp + hsw) ? pol : ~pol;
      vs  = (v >= vv + vfp && v < vv + vfp + vsw) ? pol : ~pol;
      ls  = (h == 0);
      fs  = (h == 0) && (v == 0);
      return {11'(h), 11'(v), hcv, vcv, de, hs, vs, ls, fs};
   endfunction

   // Advance one clock, then check all three instances against the model and collect statistics.
   task automatic step();
      @(posedge clk);
      if (rst) t = 0;
      else     t = t + 1;
      #1;
      check_eq("def_outs", 64'({d_hc, d_vc, d_hcv, d_vcv, d_de, d_hs, d_vs, d_ls, d_fs}),
               64'(model_outs(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
      check_eq("small_outs", 64'({s_hc, s_vc, s_hcv, s_vcv, s_de, s_hs, s_vs, s_ls, s_fs}),
               64'(model_outs(t, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, 1'b0)));
      check_eq("mid_outs", 64'({m_hc, m_vc, m_hcv, m_vcv, m_de, m_hs, m_vs, m_ls, m_fs}),
               64'(model_outs(t, M_HV, M_HFP, M_HS, M_HBP, M_VV, M_VFP, M_VS, M_VBP, 1'b1)));
      if (stats_on != 0) begin
         if (t < S_P) begin
            s_de_n += int'(s_de); s_hs_n += int'(!s_hs); s_vs_n += int'(!s_vs); s_ls_n += int'(s_ls);
         end
         if (t < M_P) begin
            m_de_n += int'(m_de); m_hs_n += int'(m_hs); m_vs_n += int'(m_vs); m_ls_n += int'(m_ls);
         end
         if (s_fs) begin
            if (s_last_fs >= 0) check_eq("small_frame_period", 64'(t - s_last_fs), 64'(S_P));
            s_last_fs = t;
         end
         if (m_fs) begin
            if (m_last_fs >= 0) check_eq("mid_frame_period", 64'(t - m_last_fs), 64'(M_P));
            m_last_fs = t;
         end
      end
   endtask

   // Directed checks on the default instance at the horizontal boundaries.
   task automatic line_points();
      case (t)
         639: begin
            check_eq("hcv_at_639", 64'(d_hcv), 64'd640);
            check_eq("de_at_639", 64'(d_de), 64'd1);
         end
         640: begin
            check_eq("hcv_at_640", 64'(d_hcv), 64'd0);
            check_eq("de_at_640", 64'(d_de), 64'd0);
         end
         655: check_eq("hsync_at_655", 64'(d_hs), 64'd1);
         656: check_eq("hsync_at_656", 64'(d_hs), 64'd0);
         751: check_eq("hsync_at_751", 64'(d_hs), 64'd0);
         752: check_eq("hsync_at_752", 64'(d_hs), 64'd1);
         799: check_eq("hc_at_799", 64'(d_hc), 64'd799);
         800: begin
            check_eq("hc_wrap", 64'(d_hc), 64'd0);
            check_eq("vc_inc", 64'(d_vc), 64'd1);
            check_eq("line_start_wrap", 64'(d_ls), 64'd1);
         end
         default: ;
      endcase
   endtask

   initial begin
      // Power-up reset.
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < 1630; i++) begin
         step();
         line_points();
      end
      // Mid-frame reset: mid instance at hc=30, vc=20; small instance inside its hsync.
      check_eq("mid_pre_hc", 64'(m_hc), 64'd30);
      check_eq("mid_pre_vc", 64'(m_vc), 64'd20);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("rst_hc", 64'(d_hc), 64'd0);
         check_eq("rst_vc", 64'(d_vc), 64'd0);
         check_eq("rst_hcv", 64'(d_hcv), 64'd1);
         check_eq("rst_vcv", 64'(d_vcv), 64'd1);
         check_eq("rst_fs", 64'(d_fs), 64'd1);
         check_eq("rst_syncs", 64'({d_hs, d_vs}), 64'd3);
         check_eq("rst_small_hsync", 64'(s_hs), 64'd1);
         check_eq("rst_mid_hc", 64'(m_hc), 64'd0);
      end
      rst = 1'b0;
      step();
      check_eq("rel_hc", 64'(d_hc), 64'd1);
      check_eq("rel_hcv", 64'(d_hcv), 64'd2);
      check_eq("rel_fs", 64'(d_fs), 64'd0);

      // Two uninterrupted mid-size frames. Statistics cover the first frame of each instance.
      rst = 1'b1;
      stats_on = 1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 2 * M_P; i++) step();
      stats_on = 0;
      check_eq("small_de_count", 64'(s_de_n), 64'(S_HV * S_VV));
      check_eq("small_hsync_count", 64'(s_hs_n), 64'(S_HS * 7));
      check_eq("small_vsync_count", 64'(s_vs_n), 64'(S_VS * 12));
      check_eq("small_line_starts", 64'(s_ls_n), 64'd7);
      check_eq("mid_de_count", 64'(m_de_n), 64'(M_HV * M_VV));
      check_eq("mid_hsync_count", 64'(m_hs_n), 64'(M_HS * 58));
      check_eq("mid_vsync_count", 64'(m_vs_n), 64'(M_VS * 80));
      check_eq("mid_line_starts", 64'(m_ls_n), 64'd58);
      check_eq("mid_last_fs", 64'(m_last_fs), 64'(2 * M_P));

      // Random run lengths separated by random reset pulses.
      for (int k = 0; k < 15; k++) begin
         int run_len;
         int rst_len;
         run_len = int'($urandom_range(1500, 0));
         rst_len = int'($urandom_range(4, 1));
         for (int i = 0; i < run_len; i++) step();
         rst = 1'b1;
         for (int i = 0; i < rst_len; i++) step();
         rst = 1'b0;
      end
      for (int i = 0; i < 100; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
